// File: rtl/period_meter.sv
// period_meter
// Measures the period and the high time of a slow asynchronous input in i_clk
// cycles. Each full period is handed to the consumer through a valid/ack
// handshake. Sticky flags report a missing rising edge (timeout) and a result
// overwritten before it was acknowledged (overrun).
//
// Build option: define PERIOD_METER_HIGH_TIME_EN to build falling-edge
// detection and the high-time register. Without it o_high_time is tied to 0.
// The period path is the same in both builds.
module period_meter #(
  parameter int CNT_W       = 26,  // counter / result width, >= 4
  parameter int SYNC_STAGES = 2    // synchronizer depth on i_sig_in, >= 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_sig_in,
  input  logic             i_ack,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high_time,
  output logic             o_valid,
  output logic             o_timeout,
  output logic             o_overrun
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_LOW  = 2'd1;
  localparam logic [1:0] ST_WAIT_RISE = 2'd2;
  localparam logic [1:0] ST_MEASURE   = 2'd3;

  // Last count value before the counter range runs out: 2^CNT_W - 2.
  // A rise seen at this count still reports 2^CNT_W - 1, the largest period.
  localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_period;
  logic                   r_valid;
  logic                   r_timeout;
  logic                   r_overrun;

  logic                   w_sync_out;
  logic                   w_rise;
  logic                   w_measuring;
  logic                   w_result;
  logic                   w_expire;
  logic [CNT_W-1:0]       w_cnt_inc;

  // Synchronizer chain on the asynchronous input, followed by an edge-detect delay flop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig_in};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_sync_out  = r_sync[SYNC_STAGES-1];
  assign w_rise      = w_sync_out & ~r_dly;
  assign w_measuring = i_en & (r_state == ST_MEASURE);

  // The count is one behind the elapsed cycles: cnt restarts at 0 on the
  // detected rise, so "cnt + 1" is the exact cycle distance at the next edge.
  assign w_cnt_inc = r_cnt + CNT_ONE;
  assign w_result  = w_measuring & w_rise;
  assign w_expire  = w_measuring & ~w_rise & (r_cnt == CNT_LAST);

  // Control FSM and the cycle counter; dropping i_en aborts from any state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (!i_en) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_WAIT_LOW;
        end
        // An input that is already high must be seen low first, otherwise
        // the enable moment itself would look like a rising edge.
        ST_WAIT_LOW: begin
          if (!w_sync_out) begin
            r_state <= ST_WAIT_RISE;
          end
        end
        // The first rise only arms the measurement; it produces no result.
        ST_WAIT_RISE: begin
          if (w_rise) begin
            r_cnt   <= '0;
            r_state <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (w_rise) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_WAIT_LOW;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Period result register; held while idle so software can still read it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_period <= '0;
    end else if (w_result) begin
      r_period <= w_cnt_inc;
    end
  end

  // Handshake and sticky flags; a new result has priority over an ack
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
    end else if (!i_en) begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_result) begin
        r_valid <= 1'b1;
        // Overwriting an unconsumed result is an overrun, unless the
        // consumer takes the old one in this very cycle.
        if (r_valid && !i_ack) begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_ack) begin
        r_valid <= 1'b0;
      end
      if (w_expire) begin
        r_timeout <= 1'b1;
      end
    end
  end

`ifdef PERIOD_METER_HIGH_TIME_EN
  logic             w_fall;
  logic [CNT_W-1:0] r_hi_cnt;
  logic [CNT_W-1:0] r_high_time;

  assign w_fall = ~w_sync_out & r_dly;

  // Capture the high time of the running period at its falling edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi_cnt <= '0;
    end else if (w_measuring && w_fall) begin
      r_hi_cnt <= w_cnt_inc;
    end
  end

  // Publish the high time together with the period it belongs to
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_high_time <= '0;
    end else if (w_result) begin
      r_high_time <= r_hi_cnt;
    end
  end

  assign o_high_time = r_high_time;
`else
  assign o_high_time = '0;
`endif

  assign o_period  = r_period;
  assign o_valid   = r_valid;
  assign o_timeout = r_timeout;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_period_meter.sv
`timescale 1ns/1ps
// Self-checking bench for period_meter. Expected results come from a
// timeline model: every driven rising/falling input edge is logged with the
// clock edge that first samples it; each pair of consecutive rises yields one
// result (period = distance between rises, high time = fall - earlier rise)
// visible SYNC clock edges after the later rise.
module tb_period_meter;

  localparam int SYNC = 2;
  localparam int W    = 26;
  localparam int W8   = 8;
`ifdef PERIOD_METER_HIGH_TIME_EN
  localparam bit HT_EN = 1'b1;
`else
  localparam bit HT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, en, sig, ack;
  logic [W-1:0] period, high_time;
  logic         valid, timeout, overrun;
  logic [W8-1:0] p8, h8;
  logic          v8, t8, o8;

  int cyc = 0;
  int ctr = 0;
  int n_tests = 0;
  int n_fail  = 0;
  bit mon_on  = 1'b0;
  int rises[$], falls[$];
  int obs_t[$], obs_p[$], obs_h[$];
  int exp_t[$], exp_p[$], exp_h[$];

  period_meter #(.CNT_W(W), .SYNC_STAGES(SYNC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sig_in(sig), .i_ack(ack),
    .o_period(period), .o_high_time(high_time), .o_valid(valid),
    .o_timeout(timeout), .o_overrun(overrun)
  );

  period_meter #(.CNT_W(W8), .SYNC_STAGES(SYNC)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sig_in(sig), .i_ack(ack),
    .o_period(p8), .o_high_time(h8), .o_valid(v8),
    .o_timeout(t8), .o_overrun(o8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Collect every cycle where the main DUT presents a valid result
  always @(negedge clk) begin
    if (mon_on && valid) begin
      obs_t.push_back(cyc);
      obs_p.push_back(int'(period));
      obs_h.push_back(int'(high_time));
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d, required finish earlier", cyc);
    $fatal(1);
  end

  // Drive one cycle of input level, logging edges with the clock edge that samples them
  task automatic drive(input logic v);
    @(negedge clk);
    if (v && !sig) rises.push_back(cyc + 1);
    else if (!v && sig) falls.push_back(cyc + 1);
    sig = v;
  endtask

  task automatic div_tick(input int b);
    ctr++;
    drive(logic'(ctr[b]));
  endtask

  task automatic clear_log();
    rises.delete(); falls.delete();
    obs_t.delete(); obs_p.delete(); obs_h.delete();
  endtask

  task automatic restart();
    @(negedge clk);
    en = 1'b0;
    repeat (3) drive(1'b0);
    en = 1'b1;
    repeat (8) drive(1'b0);
    clear_log();
    ctr = 0;
  endtask

  // Reference model: results from consecutive rises
  task automatic build_exp();
    int f;
    exp_t.delete(); exp_p.delete(); exp_h.delete();
    for (int k = 1; k < rises.size(); k++) begin
      f = -1;
      foreach (falls[j]) if (f < 0 && falls[j] > rises[k-1] && falls[j] < rises[k]) f = falls[j];
      exp_t.push_back(rises[k] + SYNC);
      exp_p.push_back(rises[k] - rises[k-1]);
      exp_h.push_back(HT_EN ? (f - rises[k-1]) : 0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; sig = 1'b0; ack = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({period, high_time, valid, timeout, overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got period=%0d high=%0d v=%b t=%b o=%b, want all 0",
               period, high_time, valid, timeout, overrun);
    end
    n_tests++;
    if ({p8, h8, v8, t8, o8} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs8: got period=%0d high=%0d v=%b t=%b o=%b, want all 0", p8, h8, v8, t8, o8);
    end
    rst_n = 1'b1;
    $display("[TB] reset released at cycle %0d", cyc);
  endtask

  task automatic test_div8();
    ack = 1'b1;
    restart();
    mon_on = 1'b1;
    repeat (100) div_tick(2);
    repeat (4) drive(sig);
    mon_on = 1'b0;
    build_exp();
    n_tests++;
    if (obs_t.size() != exp_t.size() || obs_t.size() != 12) begin
      n_fail++;
      $display("FAIL div8_count: got %0d results, want %0d (12)", obs_t.size(), exp_t.size());
    end
    for (int i = 0; i < exp_t.size() && i < obs_t.size(); i++) begin
      $display("[TB] div8 result %0d: cyc=%0d period=%0d high=%0d", i, obs_t[i], obs_p[i], obs_h[i]);
      n_tests++;
      if (obs_t[i] !== exp_t[i] || obs_p[i] !== 8 || obs_h[i] !== exp_h[i] || obs_h[i] !== (HT_EN ? 4 : 0)) begin
        n_fail++;
        $display("FAIL div8_result[%0d]: got cyc=%0d p=%0d h=%0d, want cyc=%0d p=8 h=%0d",
                 i, obs_t[i], obs_p[i], obs_h[i], exp_t[i], exp_h[i]);
      end
    end
    n_tests++;
    if (timeout !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL div8_flags: got t=%b o=%b, want 0 0", timeout, overrun);
    end
  endtask

  task automatic test_div1024();
    ack = 1'b1;
    restart();
    mon_on = 1'b1;
    repeat (3700) div_tick(9);
    mon_on = 1'b0;
    build_exp();
    n_tests++;
    if (obs_t.size() != exp_t.size() || obs_t.size() != 3) begin
      n_fail++;
      $display("FAIL div1024_count: got %0d results, want %0d (3)", obs_t.size(), exp_t.size());
    end
    for (int i = 0; i < exp_t.size() && i < obs_t.size(); i++) begin
      $display("[TB] div1024 result %0d: cyc=%0d period=%0d high=%0d", i, obs_t[i], obs_p[i], obs_h[i]);
      n_tests++;
      if (obs_t[i] !== exp_t[i] || obs_p[i] !== 1024 || obs_h[i] !== (HT_EN ? 512 : 0)) begin
        n_fail++;
        $display("FAIL div1024_result[%0d]: got cyc=%0d p=%0d h=%0d, want cyc=%0d p=1024 h=%0d",
                 i, obs_t[i], obs_p[i], obs_h[i], exp_t[i], HT_EN ? 512 : 0);
      end
    end
  endtask

  task automatic test_held_high();
    ack = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (4) drive(1'b1);
    en = 1'b1;
    clear_log();
    mon_on = 1'b1;
    repeat (20) drive(1'b1);
    n_tests++;
    if (obs_t.size() != 0) begin
      n_fail++;
      $display("FAIL held_high_no_result: got %0d results while held high, want 0", obs_t.size());
    end
    repeat (6) drive(1'b0);
    for (int k = 0; k < 3; k++) begin
      repeat (5) drive(1'b1);
      repeat (5) drive(1'b0);
    end
    repeat (4) drive(sig);
    mon_on = 1'b0;
    build_exp();
    n_tests++;
    if (obs_t.size() != exp_t.size() || obs_t.size() != 2) begin
      n_fail++;
      $display("FAIL held_high_count: got %0d results, want %0d (2)", obs_t.size(), exp_t.size());
    end
    for (int i = 0; i < exp_t.size() && i < obs_t.size(); i++) begin
      $display("[TB] held_high result %0d: cyc=%0d period=%0d high=%0d", i, obs_t[i], obs_p[i], obs_h[i]);
      n_tests++;
      if (obs_t[i] !== exp_t[i] || obs_p[i] !== exp_p[i] || obs_h[i] !== exp_h[i]) begin
        n_fail++;
        $display("FAIL held_high_result[%0d]: got cyc=%0d p=%0d h=%0d, want cyc=%0d p=%0d h=%0d",
                 i, obs_t[i], obs_p[i], obs_h[i], exp_t[i], exp_p[i], exp_h[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int r, to_cyc, v_seen, npulse, p_seen, h_seen;
    ack = 1'b1;
    restart();
    to_cyc = -1; v_seen = 0;
    drive(1'b1);
    r = rises[0];
    for (int i = 0; i < 300; i++) begin
      drive((i < 3) ? 1'b1 : 1'b0);
      if (t8 && to_cyc < 0) to_cyc = cyc;
      if (v8) v_seen++;
    end
    $display("[TB] timeout: rise sampled at %0d, timeout seen at %0d", r, to_cyc);
    n_tests++;
    if (to_cyc !== r + SYNC + 255) begin
      n_fail++;
      $display("FAIL timeout_cycle: got %0d, want %0d", to_cyc, r + SYNC + 255);
    end
    n_tests++;
    if (v_seen !== 0 || o8 !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_no_result: got %0d valid cycles overrun=%b, want 0 0", v_seen, o8);
    end
    npulse = 0; p_seen = -1; h_seen = -1;
    for (int i = 0; i < 30; i++) begin
      drive(((i / 4) % 2 == 0) ? 1'b1 : 1'b0);
      if (v8) begin
        npulse++;
        if (p_seen < 0) begin p_seen = int'(p8); h_seen = int'(h8); end
      end
    end
    $display("[TB] timeout resume: %0d results, first period=%0d high=%0d", npulse, p_seen, h_seen);
    n_tests++;
    if (npulse !== 3 || p_seen !== 8 || h_seen !== (HT_EN ? 4 : 0) || t8 !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_resume: got n=%0d p=%0d h=%0d t=%b, want n=3 p=8 h=%0d t=1",
               npulse, p_seen, h_seen, t8, HT_EN ? 4 : 0);
    end
  endtask

  task automatic test_overrun();
    int first_v;
    bit held;
    ack = 1'b0;
    restart();
    first_v = -1;
    for (int i = 0; i < 40; i++) begin
      div_tick(2);
      if (valid) begin first_v = cyc; break; end
    end
    $display("[TB] overrun: first result at %0d", first_v);
    n_tests++;
    if (first_v !== rises[1] + SYNC || overrun !== 1'b0 || period !== W'(8)) begin
      n_fail++;
      $display("FAIL overrun_first: got cyc=%0d o=%b p=%0d, want cyc=%0d o=0 p=8",
               first_v, overrun, period, rises[1] + SYNC);
    end
    held = 1'b1;
    for (int i = 0; i < 8; i++) begin
      div_tick(2);
      if (!valid) held = 1'b0;
    end
    n_tests++;
    if (!held || overrun !== 1'b1 || period !== W'(8)) begin
      n_fail++;
      $display("FAIL overrun_second: got held=%b o=%b p=%0d, want held=1 o=1 p=8", held, overrun, period);
    end
    ack = 1'b1;
    div_tick(2);
    ack = 1'b0;
    n_tests++;
    if (valid !== 1'b0 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_ack_clear: got v=%b o=%b, want v=0 o=1", valid, overrun);
    end
    repeat (7) div_tick(2);
    n_tests++;
    if (valid !== 1'b1 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: got v=%b o=%b, want v=1 o=1", valid, overrun);
    end
    en = 1'b0;
    div_tick(2);
    div_tick(2);
    n_tests++;
    if (valid !== 1'b0 || overrun !== 1'b0 || timeout !== 1'b0 || period !== W'(8)) begin
      n_fail++;
      $display("FAIL overrun_disable: got v=%b o=%b t=%b p=%0d, want v=0 o=0 t=0 p=8",
               valid, overrun, timeout, period);
    end
    restart();
    first_v = -1;
    for (int i = 0; i < 40; i++) begin
      div_tick(2);
      if (valid) begin first_v = cyc; break; end
    end
    repeat (7) div_tick(2);
    ack = 1'b1;
    div_tick(2);
    ack = 1'b0;
    $display("[TB] overrun: ack coincides with result at %0d", cyc);
    n_tests++;
    if (first_v < 0 || valid !== 1'b1 || overrun !== 1'b0 || period !== W'(8)) begin
      n_fail++;
      $display("FAIL ack_coincide: got first=%0d v=%b o=%b p=%0d, want v=1 o=0 p=8",
               first_v, valid, overrun, period);
    end
    div_tick(2);
    n_tests++;
    if (valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_coincide_hold: got v=%b, want 1", valid);
    end
  endtask

  task automatic test_reset_mid();
    logic prev;
    ack = 1'b1;
    restart();
    repeat (30) div_tick(2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    $display("[TB] async reset asserted at time %0t", $time);
    n_tests++;
    if ({period, high_time, valid, timeout, overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got period=%0d high=%0d v=%b t=%b o=%b, want all 0",
               period, high_time, valid, timeout, overrun);
    end
    for (int i = 0; i < 20; i++) begin
      prev = sig;
      div_tick(2);
      if (prev && !sig) break;
    end
    rst_n = 1'b1;
    clear_log();
    mon_on = 1'b1;
    repeat (40) div_tick(2);
    repeat (4) drive(sig);
    mon_on = 1'b0;
    build_exp();
    n_tests++;
    if (obs_t.size() != exp_t.size() || obs_t.size() == 0) begin
      n_fail++;
      $display("FAIL reset_mid_count: got %0d results, want %0d", obs_t.size(), exp_t.size());
    end
    for (int i = 0; i < exp_t.size() && i < obs_t.size(); i++) begin
      $display("[TB] post-reset result %0d: cyc=%0d period=%0d high=%0d", i, obs_t[i], obs_p[i], obs_h[i]);
      n_tests++;
      if (obs_t[i] !== exp_t[i] || obs_p[i] !== exp_p[i] || obs_h[i] !== exp_h[i]) begin
        n_fail++;
        $display("FAIL reset_mid_result[%0d]: got cyc=%0d p=%0d h=%0d, want cyc=%0d p=%0d h=%0d",
                 i, obs_t[i], obs_p[i], obs_h[i], exp_t[i], exp_p[i], exp_h[i]);
      end
    end
  endtask

  task automatic test_random();
    ack = 1'b1;
    restart();
    mon_on = 1'b1;
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(15, 2)) drive(1'b1);
      repeat ($urandom_range(15, 2)) drive(1'b0);
    end
    repeat (4) drive(sig);
    mon_on = 1'b0;
    build_exp();
    n_tests++;
    if (obs_t.size() != exp_t.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d results, want %0d", obs_t.size(), exp_t.size());
    end
    for (int i = 0; i < exp_t.size() && i < obs_t.size(); i++) begin
      $display("[TB] random result %0d: cyc=%0d period=%0d high=%0d", i, obs_t[i], obs_p[i], obs_h[i]);
      n_tests++;
      if (obs_t[i] !== exp_t[i] || obs_p[i] !== exp_p[i] || obs_h[i] !== exp_h[i]) begin
        n_fail++;
        $display("FAIL random_result[%0d]: got cyc=%0d p=%0d h=%0d, want cyc=%0d p=%0d h=%0d",
                 i, obs_t[i], obs_p[i], obs_h[i], exp_t[i], exp_p[i], exp_h[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    ack = 1'b1;
    restart();
    mon_on = 1'b1;
    repeat (20) begin
      repeat (2) drive(1'b1);
      repeat (2) drive(1'b0);
    end
    repeat (4) drive(sig);
    mon_on = 1'b0;
    build_exp();
    n_tests++;
    if (obs_t.size() != exp_t.size() || obs_t.size() != 19) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results, want %0d (19)", obs_t.size(), exp_t.size());
    end
    for (int i = 0; i < exp_t.size() && i < obs_t.size(); i++) begin
      $display("[TB] b2b result %0d: cyc=%0d period=%0d high=%0d", i, obs_t[i], obs_p[i], obs_h[i]);
      n_tests++;
      if (obs_t[i] !== exp_t[i] || obs_p[i] !== 4 || obs_h[i] !== (HT_EN ? 2 : 0)) begin
        n_fail++;
        $display("FAIL b2b_result[%0d]: got cyc=%0d p=%0d h=%0d, want cyc=%0d p=4 h=%0d",
                 i, obs_t[i], obs_p[i], obs_h[i], exp_t[i], HT_EN ? 2 : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_div8();
    test_div1024();
    test_held_high();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period and high time of a slow, asynchronous periodic input against the system clock, such as a divided clock output or an external strobe. Each full period is reported as a CLK-cycle count through a VALID/ACK handshake, with sticky timeout and overrun flags. The block sits beside the clock-divider logic as its consumer side: it checks divider outputs in self-test and measures unknown external rates.

## Interface
- CNT_W, 26: width of the cycle counter and of the PERIOD/HIGH_TIME outputs; minimum 4.
- SYNC_STAGES, 2: number of synchronizer flops on SIG_IN; minimum 2.

- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- EN  input  1  measurement enable; low aborts the measurement and clears the flags.
- SIG_IN  input  1  asynchronous signal under measurement.
- ACK  input  1  consumer acknowledge for VALID.
- PERIOD  output  CNT_W  CLK cycles between consecutive detected rising edges.
- HIGH_TIME  output  CNT_W  CLK cycles from a detected rise to the following detected fall.
- VALID  output  1  PERIOD/HIGH_TIME hold an unacknowledged result.
- TIMEOUT  output  1  sticky: no rising edge arrived within the counter range.
- OVERRUN  output  1  sticky: a result was overwritten before it was acknowledged.

## Operation
- SIG_IN passes through a SYNC_STAGES flop chain, then a delay flop. rise = sync_out & ~dly; fall = ~sync_out & dly.
- States:
  - IDLE: entered while EN=0. Clears cnt, TIMEOUT, OVERRUN and VALID. PERIOD and HIGH_TIME are held. Goes to WAIT_LOW when EN=1.
  - WAIT_LOW: waits for sync_out=0, so a signal that is already high never produces a false first rise. Then goes to WAIT_RISE.
  - WAIT_RISE: on rise, cnt<=0 and go to MEASURE. This first rise produces no result.
  - MEASURE: cnt increments every cycle.
    - On fall: hi_cnt<=cnt+1.
    - On rise: PERIOD<=cnt+1, HIGH_TIME<=hi_cnt, VALID<=1, cnt<=0; stay in MEASURE (back-to-back periods).
    - If cnt==2^CNT_W-2 with no rise: TIMEOUT<=1, cnt<=0, go to WAIT_LOW. No result is produced.
- Maximum reportable PERIOD is 2^CNT_W-1. All arithmetic is unsigned and never wraps.
- Handshake:
  - ACK=1 while VALID=1 clears VALID on the next edge.
  - A new result while VALID=1 and ACK=0 overwrites PERIOD/HIGH_TIME, keeps VALID=1 and sets OVERRUN.
  - A new result and ACK=1 in the same cycle loads the new data, keeps VALID=1 and does not set OVERRUN.
  - ACK while VALID=0 is ignored.
- EN dropping mid-measurement goes to IDLE on the next edge. A partial result is discarded.
- SIG_IN high and low phases must each last at least 2 CLK cycles. Narrower phases may be missed, and the measurement is then undefined but recoverable.

## Timing
- Reset (RST_N=0, asynchronous): PERIOD=0, HIGH_TIME=0, VALID=0, TIMEOUT=0, OVERRUN=0, state IDLE, all sync/delay flops 0, cnt=0.
- Latency: counting the CLK edge that first samples SIG_IN high as edge 1, VALID/PERIOD update on edge SYNC_STAGES+1.
- Latency is identical for every edge, so measured values equal the true period and high time exactly for CLK-synchronous inputs.
- A VALID result can be consumed at most once per period. With ACK tied high, VALID is a 1-cycle pulse per period.
- TIMEOUT asserts 2^CNT_W-1 cycles after the last detected rise.

## Configuration
- PERIOD_METER_HIGH_TIME_EN
  - Defined: fall detection and the hi_cnt register are built, and HIGH_TIME reports the high time.
  - Undefined: that logic is removed, and HIGH_TIME is held at 0 (the port remains).
  - PERIOD behaviour is identical either way.

## Test plan
- SIG_IN = bit 2 of a free-running counter on CLK, ACK=1, EN=1 -> after the arming period, VALID pulses every 8 cycles with PERIOD=8, HIGH_TIME=4, and no flags.
- SIG_IN = bit 9 of the same counter -> PERIOD=1024, HIGH_TIME=512. SIG_IN held high at enable -> no result until a low phase is seen.
- CNT_W=8, one rise then SIG_IN held low -> TIMEOUT=1 exactly 255 cycles after the detected rise, VALID stays 0, and measurement resumes after the next low-then-rise.
- Divide-by-8 input, ACK=0 -> VALID held and OVERRUN=1 after the second result. A 1-cycle ACK clears VALID on the next edge, OVERRUN stays 1 until EN=0, and ACK coinciding with a new result sets no OVERRUN.
- RST_N pulsed low mid-MEASURE between edges -> all outputs 0 immediately without a CLK edge. After release with EN=1, the first rise only arms.
- Build without PERIOD_METER_HIGH_TIME_EN, divide-by-8 input -> PERIOD=8, HIGH_TIME=0 throughout.
